// File: rtl/obi_sbr_mem.sv
// OBI subordinate backed by a flop memory, with in-order queued responses.
// Define OBI_SBR_MEM_ERR_INJ_EN to add the err_inject_i port.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
        bit          UseRReady;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   4,
        UseRReady: 1'b0
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module obi_sbr_mem
    import obi_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
    parameter type         obi_req_t   = obi_pkg::obi_req_t,
    parameter type         obi_rsp_t   = obi_pkg::obi_rsp_t,
    parameter int unsigned NumWords    = 256,
    parameter int unsigned Latency     = 1,
    parameter int unsigned NumMaxTrans = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
`ifdef OBI_SBR_MEM_ERR_INJ_EN
    input  logic     err_inject_i,
`endif
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o
);

    localparam int unsigned AW   = ObiCfg.AddrWidth;
    localparam int unsigned DW   = ObiCfg.DataWidth;
    localparam int unsigned IW   = ObiCfg.IdWidth;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OffW = $clog2(BW);
    localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);
    localparam int unsigned LatW = (Latency > 1) ? $clog2(Latency) : 1;

    typedef logic [LatW-1:0] lat_t;
    typedef logic [PtrW-1:0] ptr_t;

    localparam lat_t LatInit = lat_t'(Latency - 1);

    logic [DW-1:0] mem_q   [NumWords];
    logic [DW-1:0] rdata_q [NumMaxTrans];
    logic [IW-1:0] rid_q   [NumMaxTrans];
    logic          err_q   [NumMaxTrans];
    lat_t          cd_q    [NumMaxTrans];

    ptr_t            wr_ptr_q;
    ptr_t            rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic [AW-1:0]   word_idx;
    logic [IdxW-1:0] idx;
    logic            in_range;
    logic            inj;
    logic            gnt;
    logic            push;
    logic            pop;
    logic            rvalid;
    logic            rready;
    logic            err_new;
    logic            wr_en;
    logic [DW-1:0]   rdata_new;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef OBI_SBR_MEM_ERR_INJ_EN
    assign inj = err_inject_i;
`else
    assign inj = 1'b0;
`endif

    assign word_idx = obi_req_i.a.addr >> OffW;
    assign idx      = word_idx[IdxW-1:0];
    assign in_range = word_idx < AW'(NumWords);

    // No pop-through: a full queue refuses even while it drains.
    assign gnt    = !rst_i && (count_q < CntW'(NumMaxTrans));
    assign push   = obi_req_i.req && gnt;
    assign rvalid = (count_q != '0) && (cd_q[rd_ptr_q] == '0);
    assign rready = ObiCfg.UseRReady ? obi_req_i.rready : 1'b1;
    assign pop    = rvalid && rready;

    assign err_new   = !in_range || inj;
    assign wr_en     = push && obi_req_i.a.we && !err_new;
    assign rdata_new = (obi_req_i.a.we || err_new) ? '0 : mem_q[idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < BW; b++) begin
                if (obi_req_i.a.be[b]) begin
                    mem_q[idx][b*8 +: 8] <= obi_req_i.a.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NumMaxTrans; i++) begin
                rdata_q[i] <= '0;
                rid_q[i]   <= '0;
                err_q[i]   <= 1'b0;
                cd_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NumMaxTrans; i++) begin
                if (cd_q[i] != '0) begin
                    cd_q[i] <= cd_q[i] - 1'b1;
                end
            end
            if (push) begin
                rdata_q[wr_ptr_q] <= rdata_new;
                rid_q[wr_ptr_q]   <= obi_req_i.a.aid;
                err_q[wr_ptr_q]   <= err_new;
                cd_q[wr_ptr_q]    <= LatInit;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = gnt;
        obi_rsp_o.rvalid = rvalid;
        if (rvalid) begin
            obi_rsp_o.r.rdata = rdata_q[rd_ptr_q];
            obi_rsp_o.r.rid   = rid_q[rd_ptr_q];
            obi_rsp_o.r.err   = err_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Directed bench for obi_sbr_mem: three instances with Latency 1, 3 and 4.
// Define OBI_SBR_MEM_ERR_INJ_EN to also exercise the err_inject_i port.
module tb_obi_sbr_mem;
    import obi_pkg::*;

    localparam obi_cfg_t Cfg = '{
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   4,
        UseRReady: 1'b1
    };

    logic     clk;
    logic     rst;
    obi_req_t req1, req3, req4;
    obi_rsp_t rsp1, rsp3, rsp4;
`ifdef OBI_SBR_MEM_ERR_INJ_EN
    logic     inj;
`endif

    int n_cmp;
    int n_err;

    obi_sbr_mem #(
        .ObiCfg(Cfg), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
        .NumWords(256), .Latency(1), .NumMaxTrans(2)
    ) u_lat1 (
        .clk_i(clk), .rst_i(rst),
`ifdef OBI_SBR_MEM_ERR_INJ_EN
        .err_inject_i(inj),
`endif
        .obi_req_i(req1), .obi_rsp_o(rsp1)
    );

    obi_sbr_mem #(
        .ObiCfg(Cfg), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
        .NumWords(256), .Latency(3), .NumMaxTrans(2)
    ) u_lat3 (
        .clk_i(clk), .rst_i(rst),
`ifdef OBI_SBR_MEM_ERR_INJ_EN
        .err_inject_i(1'b0),
`endif
        .obi_req_i(req3), .obi_rsp_o(rsp3)
    );

    obi_sbr_mem #(
        .ObiCfg(Cfg), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
        .NumWords(256), .Latency(4), .NumMaxTrans(2)
    ) u_lat4 (
        .clk_i(clk), .rst_i(rst),
`ifdef OBI_SBR_MEM_ERR_INJ_EN
        .err_inject_i(1'b0),
`endif
        .obi_req_i(req4), .obi_rsp_o(rsp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obi_req_t mk(input logic rq, input logic we,
                                    input logic [31:0] addr,
                                    input logic [31:0] wd,
                                    input logic [3:0] be,
                                    input logic [3:0] aid,
                                    input logic rr);
        obi_req_t r;
        r.req     = rq;
        r.a.addr  = addr;
        r.a.we    = we;
        r.a.be    = be;
        r.a.wdata = wd;
        r.a.aid   = aid;
        r.rready  = rr;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req1 = mk(0, 0, 0, 0, 0, 0, 1);
        req3 = mk(0, 0, 0, 0, 0, 0, 1);
        req4 = mk(0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        n_cmp++;
        if (rsp1.gnt !== 1'b0) begin
            n_err++;
            $display("FAIL rst_gnt: got %b want 0", rsp1.gnt);
        end
        n_cmp++;
        if (rsp1.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rvalid: got %b want 0", rsp1.rvalid);
        end
        n_cmp++;
        if (rsp1.r !== '0) begin
            n_err++;
            $display("FAIL rst_r: got %h want 0", rsp1.r);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({rsp1.gnt, rsp3.gnt, rsp4.gnt} !== 3'b111) begin
            n_err++;
            $display("FAIL rel_gnt: got %b want 111",
                     {rsp1.gnt, rsp3.gnt, rsp4.gnt});
        end
        tick();
    endtask

    task automatic test_single_rw();
        req1 = mk(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd3, 1);
        #1;
        n_cmp++;
        if ({rsp1.gnt, rsp1.rvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL wr_accept gnt/rvalid: got %b want 10",
                     {rsp1.gnt, rsp1.rvalid});
        end
        tick();
        req1 = mk(1, 0, 32'h10, 0, 4'h0, 4'd5, 1);
        #1;
        n_cmp++;
        if ({rsp1.rvalid, rsp1.r.rid, rsp1.r.err} !== {1'b1, 4'd3, 1'b0}) begin
            n_err++;
            $display("FAIL wr_rsp rvalid/rid/err: got %b/%0d/%b want 1/3/0",
                     rsp1.rvalid, rsp1.r.rid, rsp1.r.err);
        end
        tick();
        req1.req = 1'b0;
        #1;
        n_cmp++;
        if ({rsp1.rvalid, rsp1.r.rid} !== {1'b1, 4'd5} ||
            rsp1.r.rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd_rsp: got v=%b rid=%0d d=%h want 1/5/deadbeef",
                     rsp1.rvalid, rsp1.r.rid, rsp1.r.rdata);
        end
        tick();
        n_cmp++;
        if (rsp1.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_one_cycle: got %b want 0", rsp1.rvalid);
        end
    endtask

    task automatic test_byte_en();
        req1 = mk(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd1, 1);
        tick();
        req1 = mk(1, 1, 32'h10, 32'h11223344, 4'b0101, 4'd2, 1);
        tick();
        req1 = mk(1, 0, 32'h10, 0, 4'h0, 4'd3, 1);
        tick();
        req1 = mk(1, 0, 32'h13, 0, 4'h0, 4'd4, 1);
        #1;
        n_cmp++;
        if (rsp1.rvalid !== 1'b1 || rsp1.r.rdata !== 32'hDE22BE44) begin
            n_err++;
            $display("FAIL byte_en: got v=%b d=%h want 1/de22be44",
                     rsp1.rvalid, rsp1.r.rdata);
        end
        tick();
        req1.req = 1'b0;
        #1;
        n_cmp++;
        if (rsp1.r.rdata !== 32'hDE22BE44 || rsp1.r.rid !== 4'd4) begin
            n_err++;
            $display("FAIL low_addr_bits: got d=%h rid=%0d want de22be44/4",
                     rsp1.r.rdata, rsp1.r.rid);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        req1 = mk(1, 1, 32'h0, 32'h12345678, 4'hF, 4'd1, 1);
        tick();
        req1 = mk(1, 1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 4'd2, 1);
        tick();
        req1 = mk(1, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 4'd6, 1);
        tick();
        req1 = mk(1, 0, 32'h400, 0, 4'h0, 4'd7, 1);
        #1;
        n_cmp++;
        if ({rsp1.rvalid, rsp1.r.err, rsp1.r.rid} !== {1'b1, 1'b1, 4'd6} ||
            rsp1.r.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL oor_wr: got v=%b e=%b rid=%0d d=%h want 1/1/6/0",
                     rsp1.rvalid, rsp1.r.err, rsp1.r.rid, rsp1.r.rdata);
        end
        tick();
        req1 = mk(1, 0, 32'h0, 0, 4'h0, 4'd8, 1);
        #1;
        n_cmp++;
        if ({rsp1.rvalid, rsp1.r.err, rsp1.r.rid} !== {1'b1, 1'b1, 4'd7} ||
            rsp1.r.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL oor_rd: got v=%b e=%b rid=%0d d=%h want 1/1/7/0",
                     rsp1.rvalid, rsp1.r.err, rsp1.r.rid, rsp1.r.rdata);
        end
        tick();
        req1.req = 1'b0;
        #1;
        n_cmp++;
        if (rsp1.r.err !== 1'b0 || rsp1.r.rdata !== 32'h12345678) begin
            n_err++;
            $display("FAIL oor_word0: got e=%b d=%h want 0/12345678",
                     rsp1.r.err, rsp1.r.rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr [4];
        logic [31:0] exp_d [4];
        logic        exp_e [4];
        addr  = '{32'h10, 32'h3FC, 32'h0, 32'h400};
        exp_d = '{32'hDE22BE44, 32'hA5A5A5A5, 32'h12345678, 32'h0};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                req1 = mk(1, 0, addr[i], 0, 4'h0, 4'(i + 1), 1);
            end else begin
                req1.req = 1'b0;
            end
            #1;
            if (i < 4) begin
                n_cmp++;
                if (rsp1.gnt !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_gnt[%0d]: got %b want 1", i, rsp1.gnt);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if ({rsp1.rvalid, rsp1.r.rid, rsp1.r.err} !==
                        {1'b1, 4'(i), exp_e[i-1]} ||
                    rsp1.r.rdata !== exp_d[i-1]) begin
                    n_err++;
                    $display("FAIL b2b_rsp[%0d]: got v=%b rid=%0d e=%b d=%h want 1/%0d/%b/%h",
                             i, rsp1.rvalid, rsp1.r.rid, rsp1.r.err,
                             rsp1.r.rdata, i, exp_e[i-1], exp_d[i-1]);
                end
            end
            tick();
        end
        n_cmp++;
        if (rsp1.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got %b want 0", rsp1.rvalid);
        end
    endtask

`ifdef OBI_SBR_MEM_ERR_INJ_EN
    task automatic test_err_inject();
        inj  = 1'b1;
        req1 = mk(1, 1, 32'h20, 32'hCAFEF00D, 4'hF, 4'd9, 1);
        tick();
        inj  = 1'b0;
        req1 = mk(1, 0, 32'h20, 0, 4'h0, 4'd10, 1);
        #1;
        n_cmp++;
        if ({rsp1.rvalid, rsp1.r.err, rsp1.r.rid} !== {1'b1, 1'b1, 4'd9} ||
            rsp1.r.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL inj_wr: got v=%b e=%b rid=%0d d=%h want 1/1/9/0",
                     rsp1.rvalid, rsp1.r.err, rsp1.r.rid, rsp1.r.rdata);
        end
        tick();
        req1.req = 1'b0;
        #1;
        n_cmp++;
        if ({rsp1.rvalid, rsp1.r.err, rsp1.r.rid} !== {1'b1, 1'b0, 4'd10} ||
            rsp1.r.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL inj_rd: got v=%b e=%b rid=%0d d=%h want 1/0/10/0",
                     rsp1.rvalid, rsp1.r.err, rsp1.r.rid, rsp1.r.rdata);
        end
        tick();
    endtask
`endif

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            req3 = mk(1, 1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 4'd0, 1);
            tick();
            req3.req = 1'b0;
            repeat (4) tick();
        end
        req3 = mk(1, 0, 32'h0, 0, 4'h0, 4'd1, 0);
        #1;
        n_cmp++;
        if (rsp3.gnt !== 1'b1) begin
            n_err++;
            $display("FAIL bp_gnt0: got %b want 1", rsp3.gnt);
        end
        tick();
        req3 = mk(1, 0, 32'h4, 0, 4'h0, 4'd2, 0);
        #1;
        n_cmp++;
        if (rsp3.gnt !== 1'b1) begin
            n_err++;
            $display("FAIL bp_gnt1: got %b want 1", rsp3.gnt);
        end
        tick();
        req3 = mk(1, 0, 32'h8, 0, 4'h0, 4'd3, 0);
        #1;
        n_cmp++;
        if (rsp3.gnt !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got %b want 0", rsp3.gnt);
        end
        tick();
        n_cmp++;
        if ({rsp3.gnt, rsp3.rvalid, rsp3.r.rid} !== {1'b0, 1'b1, 4'd1} ||
            rsp3.r.rdata !== 32'hA0) begin
            n_err++;
            $display("FAIL bp_head: got g=%b v=%b rid=%0d d=%h want 0/1/1/a0",
                     rsp3.gnt, rsp3.rvalid, rsp3.r.rid, rsp3.r.rdata);
        end
        tick();
        req3.rready = 1'b1;
        #1;
        n_cmp++;
        if ({rsp3.gnt, rsp3.rvalid, rsp3.r.rid} !== {1'b0, 1'b1, 4'd1} ||
            rsp3.r.rdata !== 32'hA0) begin
            n_err++;
            $display("FAIL bp_hold_nopt: got g=%b v=%b rid=%0d d=%h want 0/1/1/a0",
                     rsp3.gnt, rsp3.rvalid, rsp3.r.rid, rsp3.r.rdata);
        end
        tick();
        n_cmp++;
        if ({rsp3.gnt, rsp3.rvalid, rsp3.r.rid} !== {1'b1, 1'b1, 4'd2} ||
            rsp3.r.rdata !== 32'hA1) begin
            n_err++;
            $display("FAIL bp_second: got g=%b v=%b rid=%0d d=%h want 1/1/2/a1",
                     rsp3.gnt, rsp3.rvalid, rsp3.r.rid, rsp3.r.rdata);
        end
        tick();
        req3.req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (rsp3.rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL bp_gap[%0d]: got %b want 0", i, rsp3.rvalid);
            end
            tick();
        end
        n_cmp++;
        if ({rsp3.rvalid, rsp3.r.rid} !== {1'b1, 4'd3} ||
            rsp3.r.rdata !== 32'hA2) begin
            n_err++;
            $display("FAIL bp_third: got v=%b rid=%0d d=%h want 1/3/a2",
                     rsp3.rvalid, rsp3.r.rid, rsp3.r.rdata);
        end
        tick();
        n_cmp++;
        if (rsp3.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got %b want 0", rsp3.rvalid);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        int waited;
        req4 = mk(1, 1, 32'h0, 32'h55AA55AA, 4'hF, 4'd0, 1);
        tick();
        req4.req = 1'b0;
        repeat (5) tick();
        req4 = mk(1, 0, 32'h0, 0, 4'h0, 4'd1, 1);
        tick();
        req4 = mk(1, 0, 32'h4, 0, 4'h0, 4'd2, 1);
        tick();
        req4.req = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp4.gnt !== 1'b0 || rsp4.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst: got g=%b v=%b want 0/0",
                     rsp4.gnt, rsp4.rvalid);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rsp4.gnt !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rel_gnt: got %b want 1", rsp4.gnt);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp4.rvalid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL mid_dropped: got %0d stale rvalid cycles want 0", seen);
        end
        req4 = mk(1, 0, 32'h0, 0, 4'h0, 4'd9, 1);
        req1 = mk(1, 0, 32'h10, 0, 4'h0, 4'd9, 1);
        tick();
        req4.req = 1'b0;
        req1.req = 1'b0;
        #1;
        n_cmp++;
        if (rsp1.rvalid !== 1'b1 || rsp1.r.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL mem_clr_lat1: got v=%b d=%h want 1/0",
                     rsp1.rvalid, rsp1.r.rdata);
        end
        waited = 0;
        while (rsp4.rvalid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (rsp4.rvalid !== 1'b1 || rsp4.r.rdata !== 32'h0 ||
            rsp4.r.rid !== 4'd9) begin
            n_err++;
            $display("FAIL mem_clr_lat4: got v=%b rid=%0d d=%h want 1/9/0",
                     rsp4.rvalid, rsp4.r.rid, rsp4.r.rdata);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef OBI_SBR_MEM_ERR_INJ_EN
        inj = 1'b0;
`endif
        test_reset();
        test_single_rw();
        test_byte_en();
        test_out_of_range();
        test_back_to_back();
`ifdef OBI_SBR_MEM_ERR_INJ_EN
        test_err_inject();
`endif
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
